// File: rtl/sram_test_sequencer_pkg.sv
// sram_test_pkg
// Shared definitions for the SRAM test sequencer: FSM state encoding,
// pattern-select encodings and the data pattern generator used for both
// the write pass and the read-back comparison.
package sram_test_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_WAIT_BUSY,
        ST_WR_WAIT_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT_BUSY,
        ST_RD_WAIT_DATA,
        ST_NEXT,
        ST_DONE
    } state_t;

    localparam logic [1:0] PAT_ADDR     = 2'd0;
    localparam logic [1:0] PAT_CHECKER  = 2'd1;
    localparam logic [1:0] PAT_WALK_ONE = 2'd2;
    localparam logic [1:0] PAT_INV_ADDR = 2'd3;

    // Only the low address byte matters for every pattern.
    function automatic logic [7:0] expected_data(input logic [7:0] addr_lo,
                                                 input logic [1:0] sel);
        logic [7:0] value;
        case (sel)
            PAT_ADDR:     value = addr_lo;
            PAT_CHECKER:  value = addr_lo[0] ? 8'hAA : 8'h55;
            PAT_WALK_ONE: value = 8'h01 << addr_lo[2:0];
            default:      value = ~addr_lo;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/sram_test_sequencer_timeout.sv
// sram_test_timeout
// Loadable down-counter guarding every wait on the SRAM controller.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   load         : reload the counter (issued in each request cycle)
//   enable       : count down (asserted while waiting on the controller)
//   expired      : counter has reached zero
module sram_test_timeout
    import sram_test_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // Reloaded with one less than the limit so that expiry coincides with
    // the last permitted wait cycle.
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sram_test_sequencer.sv
// sram_test_sequencer
// Drives single-word requests into the 512Kx8 SRAM controller, writes a
// generated pattern over [FIRST_ADDR, LAST_ADDR], reads it back and counts
// mismatches.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   start_test, pattern_sel : start a pass / pattern choice (latched)
//   start_operation, rw,
//   address_output, data_f2s: request side of the controller interface
//   data_s2f, data_ready_signal, busy_signal : controller responses
//   test_running, test_done, test_pass, timeout_error,
//   error_count, first_error_address          : status for the board
module sram_test_sequencer
    import sram_test_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 19,
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] FIRST_ADDR     = '0,
    parameter logic [ADDR_WIDTH-1:0] LAST_ADDR      = 19'h7FFFF,
    parameter int                    TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_test,
    input  logic [1:0]            pattern_sel,
    output logic                  start_operation,
    output logic                  rw,
    output logic [ADDR_WIDTH-1:0] address_output,
    output logic [DATA_WIDTH-1:0] data_f2s,
    input  logic [DATA_WIDTH-1:0] data_s2f,
    input  logic                  data_ready_signal,
    input  logic                  busy_signal,
    output logic                  test_running,
    output logic                  test_done,
    output logic                  test_pass,
    output logic                  timeout_error,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] first_error_address
);

    state_t                state;
    logic [1:0]            pattern;
    logic                  timer_load;
    logic                  timer_enable;
    logic                  timer_expired;
    logic                  wait_done;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [DATA_WIDTH-1:0] next_data;
    logic [DATA_WIDTH-1:0] first_data_latched;
    logic [DATA_WIDTH-1:0] first_data_start;

    assign next_addr          = address_output + ADDR_WIDTH'(1);
    assign cur_data           = DATA_WIDTH'(expected_data(address_output[7:0], pattern));
    assign next_data          = DATA_WIDTH'(expected_data(next_addr[7:0], pattern));
    assign first_data_latched = DATA_WIDTH'(expected_data(FIRST_ADDR[7:0], pattern));
    assign first_data_start   = DATA_WIDTH'(expected_data(FIRST_ADDR[7:0], pattern_sel));

    // The timeout budget is shared by all wait states of one request.
    assign timer_load   = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    assign timer_enable = (state == ST_WR_WAIT_BUSY) || (state == ST_WR_WAIT_IDLE) ||
                          (state == ST_RD_WAIT_BUSY) || (state == ST_RD_WAIT_DATA);

    always_comb begin
        wait_done = 1'b0;
        case (state)
            ST_WR_WAIT_BUSY: wait_done = busy_signal;
            ST_WR_WAIT_IDLE: wait_done = !busy_signal;
            ST_RD_WAIT_BUSY: wait_done = busy_signal;
            ST_RD_WAIT_DATA: wait_done = data_ready_signal;
            default:         wait_done = 1'b0;
        endcase
    end

    sram_test_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // start_operation is raised on entry to a REQ state, so the pulse lines
    // up with the REQ cycle. A response arriving in the expiry cycle still
    // wins over the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= ST_IDLE;
            pattern             <= PAT_ADDR;
            start_operation     <= 1'b0;
            rw                  <= 1'b0;
            address_output      <= '0;
            data_f2s            <= '0;
            test_running        <= 1'b0;
            test_done           <= 1'b0;
            test_pass           <= 1'b0;
            timeout_error       <= 1'b0;
            error_count         <= '0;
            first_error_address <= '0;
        end else begin
            start_operation <= 1'b0;
            test_done       <= 1'b0;
            if (timer_enable && !wait_done && timer_expired) begin
                timeout_error <= 1'b1;
                test_done     <= 1'b1;
                test_pass     <= 1'b0;
                test_running  <= 1'b0;
                state         <= ST_DONE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // The busy gate keeps a fresh pass from overlapping an
                        // access the controller is still finishing after reset.
                        if (start_test && !busy_signal) begin
                            pattern             <= pattern_sel;
                            address_output      <= FIRST_ADDR;
                            data_f2s            <= first_data_start;
                            rw                  <= 1'b0;
                            error_count         <= '0;
                            first_error_address <= '0;
                            timeout_error       <= 1'b0;
                            test_pass           <= 1'b0;
                            test_running        <= 1'b1;
                            start_operation     <= 1'b1;
                            state               <= ST_WR_REQ;
                        end
                    end
                    ST_WR_REQ:       state <= ST_WR_WAIT_BUSY;
                    ST_WR_WAIT_BUSY: if (wait_done) state <= ST_WR_WAIT_IDLE;
                    ST_WR_WAIT_IDLE: if (wait_done) state <= ST_NEXT;
                    ST_RD_REQ:       state <= ST_RD_WAIT_BUSY;
                    ST_RD_WAIT_BUSY: if (wait_done) state <= ST_RD_WAIT_DATA;
                    ST_RD_WAIT_DATA: begin
                        if (wait_done) begin
                            if (data_s2f != cur_data) begin
                                if (error_count != 16'hFFFF) begin
                                    error_count <= error_count + 16'd1;
                                end
                                if (error_count == 16'd0) begin
                                    first_error_address <= address_output;
                                end
                            end
                            state <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        // Equality against LAST_ADDR ends each pass, so a range
                        // reaching the top of memory never relies on wrap-around.
                        if (address_output == LAST_ADDR) begin
                            if (!rw) begin
                                address_output  <= FIRST_ADDR;
                                data_f2s        <= first_data_latched;
                                rw              <= 1'b1;
                                start_operation <= 1'b1;
                                state           <= ST_RD_REQ;
                            end else begin
                                test_done    <= 1'b1;
                                test_pass    <= (error_count == 16'd0) && !timeout_error;
                                test_running <= 1'b0;
                                state        <= ST_DONE;
                            end
                        end else begin
                            address_output  <= next_addr;
                            data_f2s        <= next_data;
                            start_operation <= 1'b1;
                            state           <= rw ? ST_RD_REQ : ST_WR_REQ;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_test_sequencer.sv
// tb_sram_test_sequencer
// Two sequencer instances (range 0..15 and the single top address 0x7FFFF),
// each driven by a behavioural SRAM controller model with random latency,
// optional read corruption, a hang on a chosen write and a forced-busy mode.
module tb_sram_test_sequencer;

    localparam int AW = 19;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_test          [2];
    logic [1:0]    pattern_sel         [2];
    logic          start_operation     [2];
    logic          rw                  [2];
    logic [AW-1:0] address_output      [2];
    logic [DW-1:0] data_f2s            [2];
    logic [DW-1:0] data_s2f            [2];
    logic          data_ready_signal   [2];
    logic          busy_signal         [2];
    logic          test_running        [2];
    logic          test_done           [2];
    logic          test_pass           [2];
    logic          timeout_error       [2];
    logic [15:0]   error_count         [2];
    logic [AW-1:0] first_error_address [2];

    // Fault controls for the controller model of instance 0.
    logic [7:0] stuck_mask;
    logic [7:0] flip_map [16];
    logic       stuck_busy;
    int         hang_write;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Observations captured in the test_done cycle.
    bit            obs_done;
    logic          obs_pass;
    logic          obs_tmo;
    logic          obs_running;
    logic [15:0]   obs_errs;
    logic [AW-1:0] obs_ferr;
    int            obs_done_cycle;
    int            obs_last_start;
    int            obs_viol;
    logic [AW-1:0] obs_wr_addr [$];
    logic [7:0]    obs_wr_data [$];
    logic [AW-1:0] obs_rd_addr [$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    sram_test_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIRST_ADDR(19'd0),
        .LAST_ADDR(19'd15), .TIMEOUT_CYCLES(15)
    ) dut_low (
        .clk(clk), .reset_n(reset_n),
        .start_test(start_test[0]), .pattern_sel(pattern_sel[0]),
        .start_operation(start_operation[0]), .rw(rw[0]),
        .address_output(address_output[0]), .data_f2s(data_f2s[0]),
        .data_s2f(data_s2f[0]), .data_ready_signal(data_ready_signal[0]),
        .busy_signal(busy_signal[0]), .test_running(test_running[0]),
        .test_done(test_done[0]), .test_pass(test_pass[0]),
        .timeout_error(timeout_error[0]), .error_count(error_count[0]),
        .first_error_address(first_error_address[0])
    );

    sram_test_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIRST_ADDR(19'h7FFFF),
        .LAST_ADDR(19'h7FFFF), .TIMEOUT_CYCLES(15)
    ) dut_top (
        .clk(clk), .reset_n(reset_n),
        .start_test(start_test[1]), .pattern_sel(pattern_sel[1]),
        .start_operation(start_operation[1]), .rw(rw[1]),
        .address_output(address_output[1]), .data_f2s(data_f2s[1]),
        .data_s2f(data_s2f[1]), .data_ready_signal(data_ready_signal[1]),
        .busy_signal(busy_signal[1]), .test_running(test_running[1]),
        .test_done(test_done[1]), .test_pass(test_pass[1]),
        .timeout_error(timeout_error[1]), .error_count(error_count[1]),
        .first_error_address(first_error_address[1])
    );

    // Controller model: a request raises busy for a random 1..6 cycles; reads
    // return stored data together with data_ready as busy drops.
    for (genvar g = 0; g < 2; g++) begin : gen_model
        logic [7:0]    mem [int unsigned];
        logic          busy_q  = 1'b0;
        logic          ready_q = 1'b0;
        logic [7:0]    rdata_q = 8'h00;
        logic          cur_rw  = 1'b0;
        logic [AW-1:0] cur_addr = '0;
        int            cnt = 0;
        int            wr_seen = 0;
        int            viol = 0;
        int            last_start = 0;
        logic [AW-1:0] wr_addr_log [$];
        logic [7:0]    wr_data_log [$];
        logic [AW-1:0] rd_addr_log [$];

        assign busy_signal[g]       = busy_q | ((g == 0) && stuck_busy);
        assign data_ready_signal[g] = ready_q;
        assign data_s2f[g]          = rdata_q;

        always @(posedge clk) begin
            logic [7:0] v;
            ready_q <= 1'b0;
            if (!test_running[g]) begin
                wr_seen = 0;
                wr_addr_log.delete();
                wr_data_log.delete();
                rd_addr_log.delete();
            end
            if (test_running[g] && cnt != 0 &&
                (address_output[g] != cur_addr || rw[g] != cur_rw)) viol++;
            if (start_operation[g] && cnt != 0) viol++;
            if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    busy_q <= 1'b0;
                    if (cur_rw) begin
                        v = mem.exists(cur_addr) ? mem[cur_addr] : 8'h00;
                        if (g == 0) v = (v & ~stuck_mask) ^ flip_map[cur_addr[3:0]];
                        rdata_q <= v;
                        ready_q <= 1'b1;
                    end
                end
            end else if (start_operation[g]) begin
                cur_rw     = rw[g];
                cur_addr   = address_output[g];
                last_start = cycle;
                if (!cur_rw) begin
                    mem[cur_addr] = data_f2s[g];
                    wr_addr_log.push_back(cur_addr);
                    wr_data_log.push_back(data_f2s[g]);
                end else begin
                    rd_addr_log.push_back(cur_addr);
                end
                if (!(g == 0 && !cur_rw && wr_seen == hang_write)) begin
                    busy_q <= 1'b1;
                    cnt = int'($urandom_range(1, 6));
                end
                if (!cur_rw) wr_seen++;
            end
        end
    end

    function automatic logic [7:0] refPattern(input int unsigned a, input logic [1:0] sel);
        case (sel)
            2'd0:    return 8'(a % 256);
            2'd1:    return (a % 2 == 0) ? 8'h55 : 8'hAA;
            2'd2:    return 8'(1 << (a % 8));
            default: return 8'(255 - (a % 256));
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic capture(input int which);
        obs_pass       = test_pass[which];
        obs_tmo        = timeout_error[which];
        obs_running    = test_running[which];
        obs_errs       = error_count[which];
        obs_ferr       = first_error_address[which];
        obs_done_cycle = cycle;
        if (which == 0) begin
            obs_last_start = gen_model[0].last_start;
            obs_viol       = gen_model[0].viol;
            obs_wr_addr    = gen_model[0].wr_addr_log;
            obs_wr_data    = gen_model[0].wr_data_log;
            obs_rd_addr    = gen_model[0].rd_addr_log;
        end else begin
            obs_last_start = gen_model[1].last_start;
            obs_viol       = gen_model[1].viol;
            obs_wr_addr    = gen_model[1].wr_addr_log;
            obs_wr_data    = gen_model[1].wr_data_log;
            obs_rd_addr    = gen_model[1].rd_addr_log;
        end
    endtask

    // Starts one pass and waits (bounded) for its test_done pulse.
    task automatic applyStimulus(input int which, input logic [1:0] sel);
        bit accepted;
        accepted = 0;
        obs_done = 0;
        @(negedge clk);
        pattern_sel[which] = sel;
        start_test[which]  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (test_running[which]) begin
                accepted = 1;
                break;
            end
        end
        start_test[which] = 1'b0;
        checkOutput("start_accept", 32'(accepted), 32'd1);
        if (accepted) begin
            checkOutput("start_clears_tmo", 32'(timeout_error[which]), 32'd0);
            checkOutput("start_clears_pass", 32'(test_pass[which]), 32'd0);
            checkOutput("start_clears_errs", 32'(error_count[which]), 32'd0);
            for (int i = 0; i < 5000; i++) begin
                @(negedge clk);
                if (test_done[which]) begin
                    obs_done = 1;
                    capture(which);
                    break;
                end
            end
            checkOutput("done_seen", 32'(obs_done), 32'd1);
            if (obs_done) begin
                @(negedge clk);
                checkOutput("done_is_pulse", 32'(test_done[which]), 32'd0);
            end
        end
    endtask

    task automatic checkRun(input int which, input logic [1:0] sel, input int unsigned first,
                            input int unsigned last, input int hang_at);
        int unsigned exp_errs;
        int unsigned exp_first;
        bit          any;
        logic [7:0]  p;
        logic [7:0]  seen;
        int          n;
        hang_write = hang_at;
        applyStimulus(which, sel);
        hang_write = -1;
        if (!obs_done) return;
        exp_errs  = 0;
        exp_first = 0;
        any       = 0;
        n         = int'(last - first + 1);
        for (int unsigned a = first; a <= last; a++) begin
            p    = refPattern(a, sel);
            seen = p;
            if (which == 0) seen = (p & ~stuck_mask) ^ flip_map[a % 16];
            if (seen != p) begin
                exp_errs++;
                if (!any) begin
                    any       = 1;
                    exp_first = a;
                end
            end
        end
        checkOutput("running_low_at_done", 32'(obs_running), 32'd0);
        if (hang_at >= 0) begin
            checkOutput("tmo_flag", 32'(obs_tmo), 32'd1);
            checkOutput("tmo_pass", 32'(obs_pass), 32'd0);
            checkOutput("tmo_err_cnt", 32'(obs_errs), 32'd0);
            checkOutput("tmo_writes", 32'(obs_wr_addr.size()), 32'(hang_at + 1));
            checkOutput("tmo_latency", 32'(obs_done_cycle - obs_last_start), 32'd16);
        end else begin
            checkOutput("tmo_flag", 32'(obs_tmo), 32'd0);
            checkOutput("err_count", 32'(obs_errs), exp_errs);
            checkOutput("first_err_addr", 32'(obs_ferr), exp_first);
            checkOutput("pass", 32'(obs_pass), 32'(exp_errs == 0));
            checkOutput("write_count", 32'(obs_wr_addr.size()), 32'(n));
            checkOutput("read_count", 32'(obs_rd_addr.size()), 32'(n));
            for (int i = 0; i < n && i < obs_wr_addr.size() && i < obs_rd_addr.size(); i++) begin
                checkOutput("wr_addr", 32'(obs_wr_addr[i]), first + 32'(i));
                checkOutput("wr_data", 32'(obs_wr_data[i]), 32'(refPattern(first + 32'(i), sel)));
                checkOutput("rd_addr", 32'(obs_rd_addr[i]), first + 32'(i));
            end
        end
        checkOutput("tmo_sticky", 32'(timeout_error[which]), 32'(hang_at >= 0));
        checkOutput("protocol", 32'(obs_viol), 32'd0);
    endtask

    initial begin
        bit found;
        int held;
        reset_n        = 1'b0;
        start_test[0]  = 1'b0;
        start_test[1]  = 1'b0;
        pattern_sel[0] = 2'd0;
        pattern_sel[1] = 2'd0;
        stuck_mask     = 8'h00;
        stuck_busy     = 1'b0;
        hang_write     = -1;
        foreach (flip_map[i]) flip_map[i] = 8'h00;

        #3;
        for (int w = 0; w < 2; w++) begin
            checkOutput("rst_flags", 32'({start_operation[w], rw[w], test_running[w],
                                          test_done[w], test_pass[w], timeout_error[w]}), 32'd0);
            checkOutput("rst_err_cnt", 32'(error_count[w]), 32'd0);
            checkOutput("rst_addr", 32'(address_output[w]), 32'd0);
            checkOutput("rst_first_err", 32'(first_error_address[w]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] address pattern, clean controller");
        checkRun(0, 2'd0, 0, 15, -1);

        $display("[TB] stuck-at-0 on read bit 3");
        stuck_mask = 8'h08;
        checkRun(0, 2'd0, 0, 15, -1);
        checkOutput("stuck3_err_cnt", 32'(obs_errs), 32'd8);
        checkOutput("stuck3_first", 32'(obs_ferr), 32'd8);
        stuck_mask = 8'h00;

        $display("[TB] walking-one pattern");
        checkRun(0, 2'd2, 0, 15, -1);

        $display("[TB] controller never busy on third write");
        checkRun(0, 2'd1, 0, 15, 2);

        $display("[TB] reset during read phase");
        pattern_sel[0] = 2'd0;
        start_test[0]  = 1'b1;
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (test_running[0]) start_test[0] = 1'b0;
            if (rw[0] && busy_signal[0]) begin
                found = 1;
                break;
            end
        end
        start_test[0] = 1'b0;
        checkOutput("reach_read_phase", 32'(found), 32'd1);
        @(negedge clk);
        stuck_busy = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_flags", 32'({start_operation[0], rw[0], test_running[0],
                                            test_done[0], test_pass[0], timeout_error[0]}), 32'd0);
        checkOutput("async_rst_addr", 32'(address_output[0]), 32'd0);
        checkOutput("async_rst_data", 32'(data_f2s[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        held = 0;
        start_test[0] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (test_running[0]) held++;
        end
        checkOutput("start_gated_by_busy", 32'(held), 32'd0);
        stuck_busy = 1'b0;
        checkRun(0, 2'd0, 0, 15, -1);

        $display("[TB] single word at top of memory");
        checkRun(1, 2'd0, 32'h7FFFF, 32'h7FFFF, -1);
        checkRun(1, 2'd3, 32'h7FFFF, 32'h7FFFF, -1);

        $display("[TB] randomized passes");
        for (int r = 0; r < 6; r++) begin
            stuck_mask = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            foreach (flip_map[i])
                flip_map[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            checkRun(0, 2'($urandom_range(0, 3)), 0, 15, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_test_sequencer.md
# sram_test_sequencer

Request-side engine for the 512K×8 SRAM controller: issues single-word write and read requests over the controller's user interface (`start_operation`/`rw`/address/data in; `busy`/`data_ready`/read data out) and runs a full write-then-verify pass over a configurable address range. Every read-back word is compared against a generated pattern. The engine reports mismatch count, first failing address and pass/fail to the board-level status logic (LEDs/UART).

## Interface
Parameters:
- `ADDR_WIDTH`, 19, controller address width
- `DATA_WIDTH`, 8, controller data width
- `FIRST_ADDR`, 0, first tested address
- `LAST_ADDR`, 19'h7FFFF, last tested address (inclusive, ≥ FIRST_ADDR)
- `TIMEOUT_CYCLES`, 15, max cycles waiting for any controller response

Ports:
- `clk` in 1: single clock, rising edge. Controller runs on the same clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start_test` in 1: level, sampled in IDLE; starts a pass.
- `pattern_sel` in 2: 0 = addr[7:0], 1 = checkerboard (0x55 if addr[0]=0, else 0xAA), 2 = walking-one (0x01 rotl addr[2:0]), 3 = inverted addr[7:0]. Sampled and held at test start.
- `start_operation` out 1: one-cycle request pulse to the controller.
- `rw` out 1: 1 = read, 0 = write. Held for the whole operation.
- `address_output` out ADDR_WIDTH: held from the request cycle until the operation completes.
- `data_f2s` out DATA_WIDTH: write data, held like the address.
- `data_s2f` in DATA_WIDTH: read data, valid when `data_ready_signal` = 1.
- `data_ready_signal` in 1: read complete.
- `busy_signal` in 1: controller busy.
- `test_running` out 1: high from accepted start until DONE.
- `test_done` out 1: one-cycle pulse at end of pass (normal or aborted).
- `test_pass` out 1: level, valid after `test_done`; 1 = zero errors and no timeout.
- `timeout_error` out 1: sticky until next start.
- `error_count` out 16: mismatches, saturates at 0xFFFF.
- `first_error_address` out ADDR_WIDTH: address of first mismatch, 0 if none.

## Operation
- States: IDLE, WR_REQ, WR_WAIT_BUSY, WR_WAIT_IDLE, RD_REQ, RD_WAIT_BUSY, RD_WAIT_DATA, NEXT, DONE.
- IDLE → WR_REQ requires `start_test`=1 **and** `busy_signal`=0. On entry the engine clears the counters, error flags and `test_pass`, latches `pattern_sel`, and sets addr = FIRST_ADDR.
- WR_REQ: drive `start_operation`=1, `rw`=0, address and pattern data. Next state is WR_WAIT_BUSY.
- WR_WAIT_BUSY: wait for `busy_signal`=1, then go to WR_WAIT_IDLE. WR_WAIT_IDLE: wait for `busy_signal`=0, then advance.
- Write pass: if addr == LAST_ADDR, reset addr to FIRST_ADDR and go to RD_REQ. Otherwise increment addr and return to WR_REQ.
- RD_REQ: `start_operation`=1, `rw`=1. RD_WAIT_BUSY: wait for `busy_signal`=1. RD_WAIT_DATA: wait for `data_ready_signal`=1, and compare `data_s2f` with the expected pattern in that same cycle.
- Mismatch: increment `error_count` (saturating). If it was the first error, capture addr.
- Read pass ends at LAST_ADDR and goes to DONE. DONE pulses `test_done`, sets `test_pass` = (error_count==0 && !timeout_error), then returns to IDLE.
- Timeout: a counter restarts at each request. If any WAIT state reaches TIMEOUT_CYCLES, set `timeout_error` and go to DONE.
- `start_test` has no effect while running.
- Address arithmetic is unsigned ADDR_WIDTH. LAST_ADDR = 2^19−1 must terminate on the equality compare, never on wrap-around.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset mid-operation: the engine returns to IDLE immediately. The controller has no reset and finishes any in-flight access itself; the IDLE busy-gate prevents overlapping requests.
- `start_operation` is high for exactly one cycle per word. It is never reasserted until the previous completion condition has been seen.
- Address, data and `rw` change only in NEXT or on start. They are stable from the request cycle through completion.
- Against the current controller, each word takes about 5 cycles per phase. A full pass over N words takes about 10·N + 3 cycles.
- `test_done` and `test_pass` update in the same cycle. `error_count` is final when `test_done` is high.

## Structure
- Package `sram_test_pkg`:
  - state enum constants
  - pattern-select encodings
  - a pure function `expected_data(addr, sel)`, so the testbench uses the identical generator.
- One sub-module is natural: `sram_test_timeout`, a loadable down-counter with an expiry flag.

## Test plan
- FIRST_ADDR=0, LAST_ADDR=15, ideal controller model, `pattern_sel`=0: 16 writes of data = addr, then 16 reads. Expect `test_done` pulse, `test_pass`=1, `error_count`=0.
- Same setup with a stuck-at-0 fault on model bit 3: expect `error_count`=8, `first_error_address`=8, `test_pass`=0.
- `pattern_sel`=2, LAST_ADDR=7: expect writes 0x01, 0x02, 0x04 … 0x80. All reads match, pass.
- Model never asserts busy on the 3rd write: after 15 cycles expect `timeout_error`=1, `test_done` pulse, `test_pass`=0.
- Assert `reset_n` during RD_WAIT_DATA: all outputs 0 asynchronously. While the model stays busy, `start_test` is held but not accepted; the new pass starts only after busy drops.
- FIRST_ADDR = LAST_ADDR = 19'h7FFFF: exactly one write and one read, no wrap, pass.
